// File: rtl/cp0_reg.sv
// cp0_reg: OpenMIPS coprocessor-0 register file.
// Count/Compare timer, Status, Cause, EPC, exception entry and MFC0 read.
module cp0_reg #(
    parameter logic [31:0] PRID_VAL   = 32'h004c0102,
    parameter logic [31:0] CONFIG_VAL = 32'h00008000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] data_i,
    input  logic [4:0]  raddr_i,
    input  logic [5:0]  int_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] current_inst_addr_i,
    input  logic        is_in_delayslot_i,
    output logic [31:0] data_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] config_o,
    output logic [31:0] prid_o,
    output logic        timer_int_o
);

    localparam logic [4:0] R_COUNT   = 5'd9;
    localparam logic [4:0] R_COMPARE = 5'd11;
    localparam logic [4:0] R_STATUS  = 5'd12;
    localparam logic [4:0] R_CAUSE   = 5'd13;
    localparam logic [4:0] R_EPC     = 5'd14;
    localparam logic [4:0] R_PRID    = 5'd15;
    localparam logic [4:0] R_CONFIG  = 5'd16;

    localparam logic [31:0] EX_INT  = 32'h1;
    localparam logic [31:0] EX_SYS  = 32'h8;
    localparam logic [31:0] EX_RI   = 32'ha;
    localparam logic [31:0] EX_TRAP = 32'hd;
    localparam logic [31:0] EX_OV   = 32'hc;
    localparam logic [31:0] EX_ERET = 32'he;

    // Cause bits software may write: IV, WP, IP1..0
    localparam logic [31:0] CAUSE_WMASK = 32'h00C00300;

    logic        exc_take;
    logic [4:0]  exc_code;
    logic [31:0] cause_wr;

    assign config_o = CONFIG_VAL;
    assign prid_o   = PRID_VAL;

    assign cause_wr = (cause_o & ~CAUSE_WMASK) | (data_i & CAUSE_WMASK);

    // Classify the MEM-stage exception and pick its ExcCode
    always_comb begin
        exc_take = 1'b1;
        exc_code = 5'd0;
        case (excepttype_i)
            EX_INT:  exc_code = 5'd0;
            EX_SYS:  exc_code = 5'd8;
            EX_RI:   exc_code = 5'd10;
            EX_TRAP: exc_code = 5'd13;
            EX_OV:   exc_code = 5'd12;
            default: exc_take = 1'b0;
        endcase
    end

    // Register state; exception/ERET updates come last so they win
    always_ff @(posedge clk) begin
        if (rst) begin
            count_o     <= 32'h0;
            compare_o   <= 32'h0;
            status_o    <= 32'h10000000;
            cause_o     <= 32'h0;
            epc_o       <= 32'h0;
            timer_int_o <= 1'b0;
        end else begin
            count_o        <= count_o + 32'd1;
            cause_o[15:10] <= int_i;
            if (compare_o != 32'h0 && count_o == compare_o) begin
                timer_int_o <= 1'b1;
            end
            if (we_i) begin
                case (waddr_i)
                    R_COUNT:   count_o <= data_i;
                    R_COMPARE: begin
                        compare_o   <= data_i;
                        timer_int_o <= 1'b0;
                    end
                    R_STATUS:  status_o <= data_i;
                    R_CAUSE:   begin
                        cause_o[9:8]   <= data_i[9:8];
                        cause_o[23:22] <= data_i[23:22];
                    end
                    R_EPC:     epc_o <= data_i;
                    default:   ;
                endcase
            end
            if (exc_take) begin
                if (!status_o[1]) begin
                    if (is_in_delayslot_i) begin
                        epc_o      <= current_inst_addr_i - 32'd4;
                        cause_o[31] <= 1'b1;
                    end else begin
                        epc_o      <= current_inst_addr_i;
                        cause_o[31] <= 1'b0;
                    end
                end
                status_o[1]  <= 1'b1;
                cause_o[6:2] <= exc_code;
            end else if (excepttype_i == EX_ERET) begin
                status_o[1] <= 1'b0;
            end
        end
    end

    // MFC0 read with forwarding of a same-cycle write
    always_comb begin
        data_o = 32'h0;
        if (rst) begin
            data_o = 32'h0;
        end else begin
            case (raddr_i)
                R_COUNT:   data_o = count_o;
                R_COMPARE: data_o = compare_o;
                R_STATUS:  data_o = status_o;
                R_CAUSE:   data_o = cause_o;
                R_EPC:     data_o = epc_o;
                R_PRID:    data_o = PRID_VAL;
                R_CONFIG:  data_o = CONFIG_VAL;
                default:   data_o = 32'h0;
            endcase
            if (we_i && waddr_i == raddr_i) begin
                case (raddr_i)
                    R_COUNT, R_COMPARE,
                    R_STATUS, R_EPC: data_o = data_i;
                    R_CAUSE:         data_o = cause_wr;
                    default:         ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cp0_reg.sv
// tb_cp0_reg: directed self-checking bench for cp0_reg.
// One task per feature, each with its own inline comparisons.
module tb_cp0_reg;

    logic        clk;
    logic        rst;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] data_i;
    logic [4:0]  raddr_i;
    logic [5:0]  int_i;
    logic [31:0] excepttype_i;
    logic [31:0] current_inst_addr_i;
    logic        is_in_delayslot_i;
    logic [31:0] data_o;
    logic [31:0] count_o;
    logic [31:0] compare_o;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;
    logic [31:0] config_o;
    logic [31:0] prid_o;
    logic        timer_int_o;

    int checks;
    int errors;

    cp0_reg dut (
        .clk                 (clk),
        .rst                 (rst),
        .we_i                (we_i),
        .waddr_i             (waddr_i),
        .data_i              (data_i),
        .raddr_i             (raddr_i),
        .int_i               (int_i),
        .excepttype_i        (excepttype_i),
        .current_inst_addr_i (current_inst_addr_i),
        .is_in_delayslot_i   (is_in_delayslot_i),
        .data_o              (data_o),
        .count_o             (count_o),
        .compare_o           (compare_o),
        .status_o            (status_o),
        .cause_o             (cause_o),
        .epc_o               (epc_o),
        .config_o            (config_o),
        .prid_o              (prid_o),
        .timer_int_o         (timer_int_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_inputs();
        we_i                = 1'b0;
        waddr_i             = 5'd0;
        data_i              = 32'h0;
        excepttype_i        = 32'h0;
        current_inst_addr_i = 32'h0;
        is_in_delayslot_i   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        int_i   = 6'd0;
        raddr_i = 5'd12;
        rst     = 1'b1;
        tick(2);
        checks++;
        if (data_o !== 32'h0) begin
            errors++;
            $display("FAIL rst_read: got %h want %h", data_o, 32'h0);
        end
        rst = 1'b0;
        tick(5);
        checks++;
        if (count_o !== 32'd5) begin
            errors++;
            $display("FAIL rst_count: got %0d want 5", count_o);
        end
        checks++;
        if (status_o !== 32'h10000000) begin
            errors++;
            $display("FAIL rst_status: got %h want 10000000", status_o);
        end
        checks++;
        if (prid_o !== 32'h004c0102 || config_o !== 32'h00008000) begin
            errors++;
            $display("FAIL rst_ids: got %h %h want 004c0102 00008000",
                     prid_o, config_o);
        end
        checks++;
        if (timer_int_o !== 1'b0 || cause_o !== 32'h0 || epc_o !== 32'h0) begin
            errors++;
            $display("FAIL rst_misc: got t=%b c=%h e=%h want 0 0 0",
                     timer_int_o, cause_o, epc_o);
        end
    endtask

    task automatic test_timer();
        tick(5);
        we_i    = 1'b1;
        waddr_i = 5'd11;
        data_i  = 32'd20;
        tick(1);
        idle_inputs();
        checks++;
        if (compare_o !== 32'd20 || count_o !== 32'd11) begin
            errors++;
            $display("FAIL cmp_write: got cmp=%0d cnt=%0d want 20 11",
                     compare_o, count_o);
        end
        tick(9);
        checks++;
        if (count_o !== 32'd20 || timer_int_o !== 1'b0) begin
            errors++;
            $display("FAIL timer_pre: got cnt=%0d t=%b want 20 0",
                     count_o, timer_int_o);
        end
        tick(1);
        checks++;
        if (timer_int_o !== 1'b1) begin
            errors++;
            $display("FAIL timer_rise: got %b want 1", timer_int_o);
        end
        tick(2);
        checks++;
        if (timer_int_o !== 1'b1) begin
            errors++;
            $display("FAIL timer_hold: got %b want 1", timer_int_o);
        end
        we_i    = 1'b1;
        waddr_i = 5'd11;
        data_i  = 32'd100;
        tick(1);
        idle_inputs();
        checks++;
        if (timer_int_o !== 1'b0) begin
            errors++;
            $display("FAIL timer_clear: got %b want 0", timer_int_o);
        end
    endtask

    task automatic test_count_write();
        we_i    = 1'b1;
        waddr_i = 5'd9;
        data_i  = 32'hFFFFFFFE;
        tick(1);
        idle_inputs();
        checks++;
        if (count_o !== 32'hFFFFFFFE) begin
            errors++;
            $display("FAIL cnt_write: got %h want fffffffe", count_o);
        end
        tick(2);
        checks++;
        if (count_o !== 32'h0) begin
            errors++;
            $display("FAIL cnt_wrap: got %h want 0", count_o);
        end
        we_i    = 1'b1;
        waddr_i = 5'd9;
        data_i  = 32'd100;
        tick(1);
        checks++;
        if (count_o !== 32'd100 || timer_int_o !== 1'b0) begin
            errors++;
            $display("FAIL cnt_100: got cnt=%0d t=%b want 100 0",
                     count_o, timer_int_o);
        end
        waddr_i = 5'd11;
        data_i  = 32'd100;
        tick(1);
        idle_inputs();
        checks++;
        if (timer_int_o !== 1'b0 || count_o !== 32'd101) begin
            errors++;
            $display("FAIL clr_wins: got t=%b cnt=%0d want 0 101",
                     timer_int_o, count_o);
        end
    endtask

    task automatic test_exceptions();
        excepttype_i        = 32'h8;
        current_inst_addr_i = 32'hBFC00100;
        is_in_delayslot_i   = 1'b0;
        tick(1);
        idle_inputs();
        checks++;
        if (epc_o !== 32'hBFC00100 || status_o !== 32'h10000002) begin
            errors++;
            $display("FAIL syscall: got epc=%h st=%h want bfc00100 10000002",
                     epc_o, status_o);
        end
        checks++;
        if (cause_o[6:2] !== 5'd8 || cause_o[31] !== 1'b0) begin
            errors++;
            $display("FAIL sys_cause: got code=%0d bd=%b want 8 0",
                     cause_o[6:2], cause_o[31]);
        end
        excepttype_i = 32'he;
        tick(1);
        idle_inputs();
        checks++;
        if (status_o !== 32'h10000000 || epc_o !== 32'hBFC00100) begin
            errors++;
            $display("FAIL eret1: got st=%h epc=%h want 10000000 bfc00100",
                     status_o, epc_o);
        end
        excepttype_i        = 32'hc;
        current_inst_addr_i = 32'h200;
        is_in_delayslot_i   = 1'b1;
        tick(1);
        idle_inputs();
        checks++;
        if (epc_o !== 32'h1FC || cause_o[31] !== 1'b1 ||
            cause_o[6:2] !== 5'd12) begin
            errors++;
            $display("FAIL ov_ds: got epc=%h bd=%b code=%0d want 1fc 1 12",
                     epc_o, cause_o[31], cause_o[6:2]);
        end
        excepttype_i        = 32'hd;
        current_inst_addr_i = 32'h300;
        is_in_delayslot_i   = 1'b0;
        tick(1);
        idle_inputs();
        checks++;
        if (epc_o !== 32'h1FC || cause_o[31] !== 1'b1 ||
            cause_o[6:2] !== 5'd13 || status_o[1] !== 1'b1) begin
            errors++;
            $display("FAIL exl_nest: got epc=%h bd=%b code=%0d exl=%b want 1fc 1 13 1",
                     epc_o, cause_o[31], cause_o[6:2], status_o[1]);
        end
        excepttype_i = 32'h5;
        tick(1);
        checks++;
        if (status_o !== 32'h10000002 || cause_o[6:2] !== 5'd13) begin
            errors++;
            $display("FAIL exc_other: got st=%h code=%0d want 10000002 13",
                     status_o, cause_o[6:2]);
        end
        excepttype_i = 32'he;
        tick(1);
        idle_inputs();
        checks++;
        if (status_o !== 32'h10000000 || epc_o !== 32'h1FC) begin
            errors++;
            $display("FAIL eret2: got st=%h epc=%h want 10000000 1fc",
                     status_o, epc_o);
        end
    endtask

    task automatic test_cause_write();
        do_reset();
        int_i   = 6'b101010;
        we_i    = 1'b1;
        waddr_i = 5'd13;
        data_i  = 32'hFFFFFFFF;
        tick(1);
        idle_inputs();
        checks++;
        if (cause_o !== 32'h00C0AB00) begin
            errors++;
            $display("FAIL cause_wr: got %h want 00c0ab00", cause_o);
        end
    endtask

    task automatic test_read_forward();
        raddr_i = 5'd12;
        we_i    = 1'b1;
        waddr_i = 5'd12;
        data_i  = 32'h1234;
        #1;
        checks++;
        if (data_o !== 32'h1234) begin
            errors++;
            $display("FAIL fwd_status: got %h want 00001234", data_o);
        end
        raddr_i = 5'd13;
        waddr_i = 5'd13;
        data_i  = 32'h0;
        #1;
        checks++;
        if (data_o !== 32'h0000A800) begin
            errors++;
            $display("FAIL fwd_cause: got %h want 0000a800", data_o);
        end
        raddr_i = 5'd15;
        waddr_i = 5'd15;
        #1;
        checks++;
        if (data_o !== 32'h004c0102) begin
            errors++;
            $display("FAIL rd_prid: got %h want 004c0102", data_o);
        end
        we_i    = 1'b0;
        raddr_i = 5'd16;
        #1;
        checks++;
        if (data_o !== 32'h00008000) begin
            errors++;
            $display("FAIL rd_config: got %h want 00008000", data_o);
        end
        raddr_i = 5'd20;
        #1;
        checks++;
        if (data_o !== 32'h0) begin
            errors++;
            $display("FAIL rd_unmapped: got %h want 0", data_o);
        end
        raddr_i = 5'd14;
        #1;
        checks++;
        if (data_o !== 32'h0) begin
            errors++;
            $display("FAIL rd_epc: got %h want 0", data_o);
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        we_i                = 1'b1;
        waddr_i             = 5'd12;
        data_i              = 32'h0;
        excepttype_i        = 32'h8;
        current_inst_addr_i = 32'h40;
        tick(1);
        idle_inputs();
        checks++;
        if (status_o !== 32'h2 || epc_o !== 32'h40) begin
            errors++;
            $display("FAIL exc_prec: got st=%h epc=%h want 2 40",
                     status_o, epc_o);
        end
        we_i    = 1'b1;
        waddr_i = 5'd14;
        data_i  = 32'hCAFE0000;
        tick(1);
        waddr_i = 5'd16;
        data_i  = 32'h0;
        tick(1);
        idle_inputs();
        checks++;
        if (epc_o !== 32'hCAFE0000 || config_o !== 32'h00008000) begin
            errors++;
            $display("FAIL b2b_wr: got epc=%h cfg=%h want cafe0000 00008000",
                     epc_o, config_o);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idle_inputs();
        int_i   = 6'd0;
        raddr_i = 5'd0;
        test_reset();
        test_timer();
        test_count_write();
        test_exceptions();
        test_cause_write();
        test_read_forward();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
